nubus_master_bridge: RTL
========================

# nubus_master_bridge

Bridges a simple CPU request/ready port onto the NuBus master controller and the NuBus AD/TM/START lines. Sits directly upstream of `nubus_master`: it raises the request that starts arbitration, then uses `owner`/`adrcy`/`dtacy` from `nubus_master` to drive address, transfer mode and write data. It captures read data and ACK status and returns them to the CPU. Locked transactions are out of scope.

## Interface
- `RETRY_MAX`, default 4: number of automatic re-issues on try-again-later status before reporting to CPU.
- `nub_clkn`  in  1  NuBus clock, inverted; all flops on its rising edge.
- `nub_resetn`  in  1  reset. **Asynchronous, active-low.**
- `cpu_valid`  in  1  request; held with payload stable until `cpu_ready`.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  write data, right-justified.
- `cpu_write`  in  1  1 = write.
- `cpu_size`  in  2  0 byte, 1 halfword, 2 word; 3 is illegal and treated as word.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  raw AD captured at ACK; valid with `cpu_ready`.
- `cpu_status`  out  2  ACK status; valid with `cpu_ready`.
- `mst_valid`  out  1  to `nubus_master` `cpu_valid`.
- `mst_lock`  out  1  to `nubus_master` `cpu_lock`; constant 0.
- `mst_owner`, `mst_adrcy`, `mst_dtacy`  in  1 each: from `nubus_master`.
- `nub_ackn`  in  1  NuBus /ACK.
- `nub_ad_i`  in  32  AD bus, sampled.
- `nub_tmn_i`  in  2  /TM1,/TM0, sampled.
- `nub_startn_o`  out  1  /START drive value.
- `nub_ad_o`  out  32; `nub_ad_oe`  out  1.
- `nub_tmn_o`  out  2; `nub_tm_oe`  out  1.

## Operation
- FSM states: IDLE, REQ, ADDR, DATA, DONE.
- IDLE: on `cpu_valid`, latch addr/wdata/write/size and go to REQ. Clear retry count.
- REQ: `mst_valid`=1. When `mst_adrcy & mst_owner` is seen, go to DATA and drop `mst_valid`.
- While `mst_adrcy & mst_owner` (address cycle):
  - `nub_startn_o`=0 and `nub_ad_oe`=`nub_tm_oe`=1.
  - `nub_tmn_o[1]` = ~write.
  - byte: `nub_tmn_o[0]`=0, AD[1:0]=addr[1:0].
  - half: `nub_tmn_o[0]`=1, AD[1:0]={addr[1],1}.
  - word: `nub_tmn_o[0]`=1, AD[1:0]=00.
  - AD[31:2]=addr[31:2].
- DATA:
  - Write: `nub_ad_o` carries data replicated across lanes (byte ×4, half ×2), `nub_ad_oe`=1.
  - Read: `nub_ad_oe`=0.
  - `nub_tm_oe`=0.
  - On `mst_dtacy & ~nub_ackn`, capture `nub_ad_i`→rdata and `~nub_tmn_i`→status.
  - Status 00 complete, 01 error, 10 timeout, 11 try-again-later.
- After capture:
  - If status=11 and retry count < `RETRY_MAX`, increment the count and return to REQ.
  - Otherwise go to DONE.
- DONE: `cpu_ready`=1 for one cycle, then IDLE. A new `cpu_valid` is accepted in IDLE only, so there is at least one idle cycle between transactions.

## Timing
- Reset values:
  - state IDLE, retry count 0.
  - `cpu_ready`, `mst_valid`, `mst_lock`, `nub_ad_oe`, `nub_tm_oe` = 0.
  - `nub_startn_o`=1, `nub_tmn_o`=11, `nub_ad_o`=0, `cpu_rdata`=0, `cpu_status`=0.
- Reset mid-transaction: all drivers disable asynchronously. No CPU completion is issued.
- `mst_valid` rises 1 cycle after `cpu_valid` is accepted. It falls the cycle after the address cycle is observed, while `mst_dtacy`=1, so `nubus_master` never re-arbitrates for the same request.
- Address-cycle outputs are combinational from `mst_adrcy`/`mst_owner` and the latched payload. They last exactly one clock.
- Minimum latency with ACK in the first data cycle: `cpu_ready` 1 cycle after the ACK edge.
- ACK while not `mst_dtacy` is ignored; such an ACK belongs to another master.
- Reading a retry costs a full re-arbitration; `RETRY_MAX`=0 reports 11 immediately.

## Structure
- A shared package `nubus_pkg` holds:
  - status constants (COMPLETE, ERROR, TIMEOUT, RETRY);
  - the size enum;
  - the state enum;
  - a function mapping (size, addr[1:0], write) to TM/AD[1:0];
  - the lane-replication function.
- Single module, no sub-modules. The package functions keep the RTL flat.

## Test plan
- Word write to 0xF0001234 with data 0xDEADBEEF:
  - address cycle shows AD=0xF0001234, /TM=01, /START=0 for 1 clock;
  - next cycle AD=0xDEADBEEF with oe=1;
  - ACK with /TM=11 → `cpu_ready` pulse, status 00.
- Byte read at 0x...03 → address cycle /TM=10, AD[1:0]=11; ACK with AD=0x11223344 gives `cpu_rdata`=0x11223344, AD oe low throughout DATA.
- ACK with try-again status three times then complete, `RETRY_MAX`=4 → four address cycles, single `cpu_ready`, status 00. With `RETRY_MAX`=0 → immediate `cpu_ready`, status 11.
- Foreign ACK asserted while in REQ (another master's cycle) → no capture; transaction completes only on own ACK.
- Reset asserted during DATA (write) → `nub_ad_oe` drops without a clock edge; after release, state IDLE and no `cpu_ready`.

Source files
------------

// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: ACK status codes, transfer size and bridge state
// encodings, and the transfer-mode and lane-replication helper functions.
`default_nettype none

package nubus_pkg;

   localparam logic [1:0] STATUS_COMPLETE = 2'b00;
   localparam logic [1:0] STATUS_ERROR    = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;
   localparam logic [1:0] STATUS_RETRY    = 2'b11;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'd0,
      SIZE_HALF    = 2'd1,
      SIZE_WORD    = 2'd2,
      SIZE_ILLEGAL = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Returns {/TM1, /TM0, AD[1:0]} for the address cycle; illegal size acts as word.
   function automatic logic [3:0] addr_mode(input size_e size, input logic [1:0] addr_lo,
                                            input logic write);
      logic [3:0] mode;
      case (size)
         SIZE_BYTE: mode = {~write, 1'b0, addr_lo};
         SIZE_HALF: mode = {~write, 1'b1, addr_lo[1], 1'b1};
         default:   mode = {~write, 1'b1, 2'b00};
      endcase
      return mode;
   endfunction

   function automatic logic [31:0] replicate_lanes(input size_e size, input logic [31:0] data);
      logic [31:0] lanes;
      case (size)
         SIZE_BYTE: lanes = {4{data[7:0]}};
         SIZE_HALF: lanes = {2{data[15:0]}};
         default:   lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nubus_master_bridge.sv
// CPU request/ready port to NuBus master bridge: requests arbitration through
// nubus_master, drives address/TM/data, captures ACK status and read data.
`default_nettype none

module nubus_master_bridge
   import nubus_pkg::*;
#(
   parameter int unsigned RETRY_MAX = 4
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic        cpu_valid,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_size,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  cpu_status,
   output logic        mst_valid,
   output logic        mst_lock,
   input  logic        mst_owner,
   input  logic        mst_adrcy,
   input  logic        mst_dtacy,
   input  logic        nub_ackn,
   input  logic [31:0] nub_ad_i,
   input  logic [1:0]  nub_tmn_i,
   output logic        nub_startn_o,
   output logic [31:0] nub_ad_o,
   output logic        nub_ad_oe,
   output logic [1:0]  nub_tmn_o,
   output logic        nub_tm_oe
);

   state_e      state;
   state_e      state_next;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   size_e       size_q;
   logic [31:0] retry_cnt;

   logic        addr_cycle;
   logic        ack_seen;
   logic [1:0]  ack_status;
   logic        retry_again;
   logic [3:0]  mode;

   // Gating with state keeps a foreign master's address/ACK cycles from leaking in.
   assign addr_cycle  = (state == ST_REQ) & mst_adrcy & mst_owner;
   assign ack_seen    = (state == ST_DATA) & mst_dtacy & ~nub_ackn;
   assign ack_status  = ~nub_tmn_i;
   assign retry_again = (ack_status == STATUS_RETRY) && (retry_cnt < RETRY_MAX);
   assign mode        = addr_mode(size_q, addr_q[1:0], write_q);
   assign mst_lock    = 1'b0;

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         write_q    <= 1'b0;
         size_q     <= SIZE_BYTE;
         retry_cnt  <= 32'd0;
         cpu_rdata  <= 32'd0;
         cpu_status <= STATUS_COMPLETE;
      end else begin
         if (state == ST_IDLE && cpu_valid) begin
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            write_q   <= cpu_write;
            size_q    <= size_e'(cpu_size);
            retry_cnt <= 32'd0;
         end
         if (ack_seen) begin
            cpu_rdata  <= nub_ad_i;
            cpu_status <= ack_status;
            if (retry_again) begin
               retry_cnt <= retry_cnt + 32'd1;
            end
         end
      end
   end

   always_comb begin
      state_next   = state;
      mst_valid    = 1'b0;
      cpu_ready    = 1'b0;
      nub_startn_o = 1'b1;
      nub_ad_o     = 32'd0;
      nub_ad_oe    = 1'b0;
      nub_tmn_o    = 2'b11;
      nub_tm_oe    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_valid) begin
               state_next = ST_REQ;
            end
         end
         // The address cycle is decoded combinationally inside REQ, so ST_ADDR is never entered.
         ST_REQ: begin
            mst_valid = 1'b1;
            if (addr_cycle) begin
               nub_startn_o = 1'b0;
               nub_ad_o     = {addr_q[31:2], mode[1:0]};
               nub_ad_oe    = 1'b1;
               nub_tmn_o    = mode[3:2];
               nub_tm_oe    = 1'b1;
               state_next   = ST_DATA;
            end
         end
         ST_DATA: begin
            nub_ad_oe = write_q;
            if (write_q) begin
               nub_ad_o = replicate_lanes(size_q, wdata_q);
            end
            if (ack_seen) begin
               state_next = retry_again ? ST_REQ : ST_DONE;
            end
         end
         ST_DONE: begin
            cpu_ready  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
